// File: rtl/packet_byte_serializer_if.sv
// Handshake bundle between a packet source, packet_byte_serializer and a UART byte sink.
// The master side is the packet source and UART model; the serializer uses the slave side.
interface packet_byte_serializer_if #(
    parameter int PACKET_WIDTH = 6
);
    localparam int PACKET_WIDTH_RAW = PACKET_WIDTH - 2;

    logic [PACKET_WIDTH_RAW-1:0][7:0] sys_packet;
    logic                             receive;
    logic [7:0]                       word;
    logic                             write;
    logic                             uart_ready;
    logic                             busy;
    logic                             done;
    logic                             dropped;

    modport master (
        output sys_packet, receive, uart_ready,
        input  word, write, busy, done, dropped
    );

    modport slave (
        input  sys_packet, receive, uart_ready,
        output word, write, busy, done, dropped
    );
endinterface

// File: rtl/packet_byte_serializer.sv
// Serializes a captured payload packet into bytes for a UART transmitter, index 0 first.
// Define PACKET_QUEUE_EN to add a one-deep pending packet register; default PACKET_WIDTH mirrors core_params.svh.
module packet_byte_serializer #(
    parameter int PACKET_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    packet_byte_serializer_if.slave      bus
);
    localparam int unsigned PACKET_WIDTH_RAW = PACKET_WIDTH - 2;
    localparam int unsigned IDX_W            = $clog2(PACKET_WIDTH_RAW) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PACKET_WIDTH_RAW - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                       state;
    logic [IDX_W-1:0]                 idx;
    logic [PACKET_WIDTH_RAW-1:0][7:0] hold;
    logic                             done_q;
    logic                             dropped_q;
    logic                             xfer;
    logic                             last_xfer;
`ifdef PACKET_QUEUE_EN
    logic [PACKET_WIDTH_RAW-1:0][7:0] pending;
    logic                             pend_valid;
`endif

    assign xfer      = (state == SEND) && bus.uart_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            hold       <= '0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
`ifdef PACKET_QUEUE_EN
            pending    <= '0;
            pend_valid <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.receive) begin
                        hold  <= bus.sys_packet;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (xfer && !last_xfer)
                        idx <= idx + IDX_W'(1);
`ifdef PACKET_QUEUE_EN
                    // A full pending slot always rejects; an empty one either buffers the
                    // packet or, on the final transfer, hands it straight to hold.
                    if (last_xfer) begin
                        done_q <= 1'b1;
                        if (pend_valid) begin
                            hold       <= pending;
                            idx        <= '0;
                            pend_valid <= 1'b0;
                            if (bus.receive)
                                dropped_q <= 1'b1;
                        end else if (bus.receive) begin
                            hold <= bus.sys_packet;
                            idx  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.receive) begin
                        if (pend_valid) begin
                            dropped_q <= 1'b1;
                        end else begin
                            pending    <= bus.sys_packet;
                            pend_valid <= 1'b1;
                        end
                    end
`else
                    if (last_xfer) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    if (bus.receive)
                        dropped_q <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.word = '0;
        if (state == SEND) begin
            for (int unsigned i = 0; i < PACKET_WIDTH_RAW; i++) begin
                if (idx == IDX_W'(i))
                    bus.word = hold[i];
            end
        end
    end

    assign bus.write   = (state == SEND);
`ifdef PACKET_QUEUE_EN
    assign bus.busy    = (state == SEND) || done_q || pend_valid;
`else
    assign bus.busy    = (state == SEND) || done_q;
`endif
    assign bus.done    = done_q;
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_packet_byte_serializer.sv
// Scoreboard bench for packet_byte_serializer with a 4-byte payload; honours PACKET_QUEUE_EN.
module tb_packet_byte_serializer;
    localparam int PW  = 6;
    localparam int RAW = PW - 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    packet_byte_serializer_if #(.PACKET_WIDTH(PW)) bus ();

    packet_byte_serializer #(.PACKET_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [7:0] sb[$];
    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int drop_cnt = 0;

    // Every presented byte must be the scoreboard head; it is retired only when accepted.
    always @(negedge clk) begin
        if (bus.done)    done_cnt++;
        if (bus.dropped) drop_cnt++;
        if (bus.write) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_byte: word=%h presented with empty scoreboard", bus.word);
            end else begin
                if (bus.word !== sb[0]) begin
                    errors++;
                    $display("FAIL byte_order: word=%h expected=%h", bus.word, sb[0]);
                end
                if (bus.uart_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic pulse_receive(input logic [RAW-1:0][7:0] p, input bit accept);
        bus.sys_packet = p;
        bus.receive    = 1'b1;
        if (accept)
            for (int i = 0; i < RAW; i++) sb.push_back(p[i]);
        @(posedge clk); #1;
        bus.receive    = 1'b0;
        bus.sys_packet = '0;
    endtask

    task automatic wait_quiet(input string name, input int d0, input int p0,
                              input int exp_done, input int exp_drop);
        int n = 0;
        while (n < 200 && (sb.size() != 0 || bus.write || bus.busy)) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: still active after %0d cycles, %0d bytes pending", name, n, sb.size());
        end
        checks++;
        if (done_cnt - d0 !== exp_done) begin
            errors++;
            $display("FAIL %s_done: pulses=%0d expected=%0d", name, done_cnt - d0, exp_done);
        end
        checks++;
        if (drop_cnt - p0 !== exp_drop) begin
            errors++;
            $display("FAIL %s_dropped: pulses=%0d expected=%0d", name, drop_cnt - p0, exp_drop);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        checks++;
        if ({bus.word, bus.write, bus.busy, bus.done, bus.dropped} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: word=%h write=%b busy=%b done=%b dropped=%b expected all 0",
                     bus.word, bus.write, bus.busy, bus.done, bus.dropped);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_baseline();
        int d0 = done_cnt, p0 = drop_cnt;
        pulse_receive({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        checks++;
        if (bus.write !== 1'b1 || bus.word !== 8'h11 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL baseline_first: write=%b word=%h busy=%b expected 1/11/1", bus.write, bus.word, bus.busy);
        end
        wait_quiet("baseline", d0, p0, 1, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL baseline_idle: busy=%b write=%b expected 0/0", bus.busy, bus.write);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt, p0 = drop_cnt;
        pulse_receive({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        @(posedge clk); #1;
        bus.uart_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.write !== 1'b1 || bus.word !== 8'h22) begin
                errors++;
                $display("FAIL stall_hold_%0d: write=%b word=%h expected 1/22", i, bus.write, bus.word);
            end
            @(posedge clk); #1;
        end
        bus.uart_ready = 1'b1;
        wait_quiet("backpressure", d0, p0, 1, 0);
    endtask

    task automatic test_collision();
        int d0 = done_cnt, p0 = drop_cnt;
        bit q;
`ifdef PACKET_QUEUE_EN
        q = 1'b1;
`else
        q = 1'b0;
`endif
        pulse_receive({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_receive({8'hAD, 8'hAC, 8'hAB, 8'hAA}, q);
        pulse_receive({8'hCD, 8'hCC, 8'hCB, 8'hCA}, 1'b0);
        checks++;
        if (q && (bus.write !== 1'b1 || bus.word !== 8'hAA)) begin
            errors++;
            $display("FAIL queue_handoff: write=%b word=%h expected 1/aa", bus.write, bus.word);
        end else if (!q && bus.write !== 1'b0) begin
            errors++;
            $display("FAIL collision_end: write=%b expected 0", bus.write);
        end
        wait_quiet("collision", d0, p0, q ? 2 : 1, q ? 1 : 2);
    endtask

    task automatic test_reset_mid();
        int d0, p0;
        pulse_receive({8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.word !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: write=%b busy=%b done=%b word=%h expected 0/0/0/00",
                     bus.write, bus.busy, bus.done, bus.word);
        end
        sb.delete();
        d0 = done_cnt;
        p0 = drop_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_receive({8'h5D, 8'h5C, 8'h5B, 8'h5A}, 1'b1);
        checks++;
        if (bus.write !== 1'b1 || bus.word !== 8'h5A) begin
            errors++;
            $display("FAIL reset_restart: write=%b word=%h expected 1/5a", bus.write, bus.word);
        end
        wait_quiet("reset_mid", d0, p0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt, p0 = drop_cnt;
        int n = 0;
        pulse_receive({8'h14, 8'h13, 8'h12, 8'h11}, 1'b1);
        while (n < 20 && bus.done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL b2b_done_wait: done=%b after %0d cycles expected 1", bus.done, n);
        end
        pulse_receive({8'h24, 8'h23, 8'h22, 8'h21}, 1'b1);
        wait_quiet("back_to_back", d0, p0, 2, 0);
    endtask

    task automatic test_random();
        int d0 = done_cnt, p0 = drop_cnt;
        for (int k = 0; k < 3; k++) begin
            logic [RAW-1:0][7:0] p;
            int n = 0;
            for (int i = 0; i < RAW; i++) p[i] = 8'($urandom);
            pulse_receive(p, 1'b1);
            while (n < 200 && (sb.size() != 0 || bus.busy)) begin
                bus.uart_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            bus.uart_ready = 1'b1;
        end
        wait_quiet("random", d0, p0, 3, 0);
    endtask

    initial begin
        bus.receive    = 1'b0;
        bus.sys_packet = '0;
        bus.uart_ready = 1'b1;
        test_reset();
        test_baseline();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
